mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-port memory, one outstanding transaction
// Define MEM_ARB_RR_EN for round-robin selection; default build gives data fixed priority.

package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_kill,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   kill_q, kill_d;
  logic   sel_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // On contention the requester that did not win last time goes first.
  assign sel_d = d_req && (!i_req || !last_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b1;
    end else if (i_gnt) begin
      last_d_q <= 1'b0;
    end else if (d_gnt) begin
      last_d_q <= 1'b1;
    end
  end
`else
  assign sel_d = d_req;
`endif

  // Reset gating keeps every output low while reset is held, even with requests pending.
  assign mem_req = (state_q == IDLE) && (i_req || d_req) && !reset;
  assign i_gnt   = mem_gnt && mem_req && !sel_d;
  assign d_gnt   = mem_gnt && mem_req && sel_d;
  assign busy    = (state_q != IDLE);

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (sel_d) begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_be    = '1;
        mem_addr  = i_addr;
      end
    end
  end

  assign i_rvalid = (state_q == WAIT_I) && mem_rvalid && !kill_q && !i_kill;
  assign d_rvalid = (state_q == WAIT_D) && mem_rvalid;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (i_gnt) begin
          state_d = WAIT_I;
          kill_d  = i_kill;
        end else if (d_gnt) begin
          state_d = WAIT_D;
        end
      end
      WAIT_I: begin
        kill_d = kill_q || i_kill;
        if (mem_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      WAIT_D: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (both MEM_ARB_RR_EN builds)
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_kill, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input logic is_d, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata);
    gnt_t g;
    g.is_d = is_d; g.addr = addr; g.we = we; g.be = be; g.wdata = wdata;
    exp_gnt.push_back(g);
  endtask

  task automatic push_rsp(input logic is_d, input logic [31:0] data);
    rsp_t r;
    r.is_d = is_d; r.data = data;
    exp_rsp.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_exclusive", {63'd0, i_gnt && d_gnt}, 64'd0);
      if (i_gnt || d_gnt) begin
        if (exp_gnt.size() == 0) begin
          chk("unexpected_gnt", {63'd0, d_gnt}, 64'hdead);
        end else begin
          gnt_t g;
          g = exp_gnt.pop_front();
          chk("gnt_src",   {63'd0, d_gnt}, {63'd0, g.is_d});
          chk("gnt_addr",  {32'd0, mem_addr}, {32'd0, g.addr});
          chk("gnt_we",    {63'd0, mem_we}, {63'd0, g.we});
          chk("gnt_be",    {60'd0, mem_be}, {60'd0, g.be});
          chk("gnt_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
        end
      end
      if (i_rvalid || d_rvalid) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", {63'd0, d_rvalid}, 64'hdead);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_src",   {63'd0, d_rvalid}, {63'd0, r.is_d});
          chk("rsp_data",  {32'd0, (d_rvalid ? d_rdata : i_rdata)}, {32'd0, r.data});
        end
      end
      if (!i_rvalid) chk("i_rdata_zero", {32'd0, i_rdata}, 64'd0);
      if (!d_rvalid) chk("d_rdata_zero", {32'd0, d_rdata}, 64'd0);
    end
  end

  initial begin
    logic exp_d;
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_kill = 1'b0; d_we = 1'b1; d_be = 4'hF;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h1; mem_gnt = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5;

    // Reset state: everything low despite active requests
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_gnts", {62'd0, i_gnt, d_gnt}, 64'd0);
    chk("rst_rvalids", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fields", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_we_be", {59'd0, mem_we, mem_be}, 64'd0);

    tick();
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; i_addr = 32'h0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Single fetch
    tick();
    i_req = 1'b1; i_addr = 32'h100; mem_gnt = 1'b1;
    push_gnt(1'b0, 32'h100, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("sf_c0_gnt", {62'd0, i_gnt, busy}, 64'b10);
    tick();
    i_req = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    chk("sf_c1_busy", {62'd0, busy, mem_req}, 64'b10);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h13;
    push_rsp(1'b0, 32'h13);
    @(negedge clk);
    chk("sf_c2_rvalid", {62'd0, i_rvalid, busy}, 64'b11);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("sf_c3_idle", {63'd0, busy}, 64'd0);

    // Contention with a 0-wait memory
    tick();
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h3000;
    d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      if (exp_d) push_gnt(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0);
      else       push_gnt(1'b0, 32'h200, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      chk("ct_req", {63'd0, mem_req}, 64'd1);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(k);
      push_rsp(exp_d, 32'h1000 + 32'(k));
      @(negedge clk);
      chk("ct_spacing", {63'd0, mem_req}, 64'd0);
      tick();
      mem_rvalid = 1'b0;
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0;
      end
    end

    // Store, with i_kill asserted alongside (must be ignored)
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2004;
    d_wdata = 32'hDEADBEEF; mem_gnt = 1'b1; i_kill = 1'b1;
    push_gnt(1'b1, 32'h2004, 1'b1, 4'b0011, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_gnt", {62'd0, d_gnt, i_gnt}, 64'b10);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    push_rsp(1'b1, 32'h55);
    @(negedge clk);
    chk("st_rvalid", {62'd0, d_rvalid, busy}, 64'b11);
    tick();
    mem_rvalid = 1'b0; i_kill = 1'b0;
    @(negedge clk);
    chk("st_idle", {63'd0, busy}, 64'd0);

    // Kill in WAIT_I, response 3 cycles later
    tick();
    i_req = 1'b1; i_addr = 32'h104; mem_gnt = 1'b1;
    push_gnt(1'b0, 32'h104, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    i_req = 1'b0; mem_gnt = 1'b0; i_kill = 1'b1;
    @(negedge clk);
    chk("kl_busy", {63'd0, busy}, 64'd1);
    tick();
    i_kill = 1'b0;
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    chk("kl_no_rvalid", {62'd0, i_rvalid, busy}, 64'b01);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("kl_idle", {63'd0, busy}, 64'd0);
    tick();
    i_req = 1'b1; i_addr = 32'h108; mem_gnt = 1'b1;
    push_gnt(1'b0, 32'h108, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    i_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    push_rsp(1'b0, 32'h77);
    @(negedge clk);
    chk("kl_next_rvalid", {63'd0, i_rvalid}, 64'd1);
    tick();
    mem_rvalid = 1'b0;

    // Kill in the same cycle as i_gnt
    i_req = 1'b1; i_addr = 32'h10C; mem_gnt = 1'b1; i_kill = 1'b1;
    push_gnt(1'b0, 32'h10C, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    i_req = 1'b0; mem_gnt = 1'b0; i_kill = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    chk("kg_no_rvalid", {63'd0, i_rvalid}, 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("kg_idle", {63'd0, busy}, 64'd0);

    // Reset mid-op in WAIT_D
    tick();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000; d_wdata = 32'h0; mem_gnt = 1'b1;
    push_gnt(1'b1, 32'h4000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rm_busy", {63'd0, busy}, 64'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rm_outputs", {58'd0, mem_req, d_gnt, i_gnt, busy, d_rvalid, i_rvalid}, 64'd0);
    chk("rm_addr", {32'd0, mem_addr}, 64'd0);
    tick();
    reset = 1'b0; d_req = 1'b0; d_be = 4'h0; d_addr = 32'h0;
    @(negedge clk);
    chk("rm_idle", {63'd0, busy}, 64'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("rm_late_rvalid", {61'd0, d_rvalid, busy, mem_req}, 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // First contention after reset: last grant reads "data"
    i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h5000; d_be = 4'hF; mem_gnt = 1'b1;
`ifdef MEM_ARB_RR_EN
    exp_d = 1'b0;
`else
    exp_d = 1'b1;
`endif
    if (exp_d) push_gnt(1'b1, 32'h5000, 1'b0, 4'hF, 32'h0);
    else       push_gnt(1'b0, 32'h400, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66;
    push_rsp(exp_d, 32'h66);
    @(negedge clk);
    tick();
    mem_rvalid = 1'b0; d_be = 4'h0; d_addr = 32'h0;

    // Stall: mem_gnt low for 5 cycles, stray mem_rvalid in IDLE
    i_req = 1'b1; i_addr = 32'h300; mem_gnt = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("sl_req", {63'd0, mem_req}, 64'd1);
      chk("sl_addr", {32'd0, mem_addr}, 64'h300);
      chk("sl_no_gnt_busy", {62'd0, i_gnt, busy}, 64'd0);
      tick();
      mem_rvalid = (c == 2);
      mem_rdata = (c == 2) ? 32'hEE : 32'h0;
    end
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_gnt = 1'b1;
    push_gnt(1'b0, 32'h300, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    tick();
    i_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h300ABC;
    push_rsp(1'b0, 32'h300ABC);
    @(negedge clk);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
